clk_en_multirate: RTL and testbench

Parametrised multirate clock-enable generator: from one master clock it produces a divided square-wave `sys_clk` plus aligned single-cycle enables at system, sample and symbol rate. It also exposes the sample and symbol phase counters. It sits at the top of the DSP chain (pulse-shaping, halfband and cascade filters, ASK datapath) and replaces fixed-ratio enable generation. It adds run/hold and symbol re-alignment.

---
 rtl/clk_en_multirate.sv | 136 +++++++++++++
 tb/tb_clk_en_multirate.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_multirate.sv
// ============================================================================
// clk_en_multirate
// ----------------------------------------------------------------------------
// Multirate clock-enable generator for the top of the DSP chain. From the one
// master clock it derives a divided square-wave sys_clk and three aligned
// single-cycle enables at system, sample and symbol rate. It also exposes
// the sample and symbol phase counters so downstream blocks can locate
// themselves within a sample or a symbol.
//
// Parameters
//   SYS_DIV  master clocks per sys_clk period (>=1). At 1, sys_clk stays 0
//            and sys_clk_en is constant-high while running.
//   SAM_DIV  sys_clk_en pulses per sample (>=1)
//   SYM_DIV  samples per symbol (>=1)
//   SAM_W    width of sam_phase
//   SYM_W    width of sym_phase
//
// Ports
//   clk         in   master clock, the only clock
//   reset       in   asynchronous active-low reset
//   run         in   1 = counters advance, 0 = hold
//   sync        in   synchronous re-align, overrides run
//   sys_clk     out  registered divided clock, clk/SYS_DIV
//   sys_clk_en  out  one-clk pulse per sys_clk period
//   sam_clk_en  out  one-clk pulse per sample
//   sym_clk_en  out  one-clk pulse per symbol
//   sam_phase   out  sys_clk_en count within the current sample
//   sym_phase   out  sample count within the current symbol
// ============================================================================
module clk_en_multirate #(
    parameter int SYS_DIV = 2,
    parameter int SAM_DIV = 4,
    parameter int SYM_DIV = 4,
    parameter int SAM_W   = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1,
    parameter int SYM_W   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             sync,
    output logic             sys_clk,
    output logic             sys_clk_en,
    output logic             sam_clk_en,
    output logic             sym_clk_en,
    output logic [SAM_W-1:0] sam_phase,
    output logic [SYM_W-1:0] sym_phase
);

    localparam int SYS_W = (SYS_DIV > 1) ? $clog2(SYS_DIV) : 1;

    localparam logic [SYS_W-1:0] SYS_MAX = SYS_W'(SYS_DIV - 1);
    localparam logic [SAM_W-1:0] SAM_MAX = SAM_W'(SAM_DIV - 1);
    localparam logic [SYM_W-1:0] SYM_MAX = SYM_W'(SYM_DIV - 1);

    // Master-clock count within one sys_clk period; not visible outside.
    logic [SYS_W-1:0] sys_cnt;

    logic [SYS_W-1:0] sys_cnt_next;
    logic [SAM_W-1:0] sam_next;
    logic [SYM_W-1:0] sym_next;
    logic             sys_clk_next;
    logic             t0;
    logic             t1;
    logic             t2;

    // Terminal terms come from the current register values, so each enable
    // is registered on the same edge that wraps its counter. That is why
    // sam_phase/sym_phase already read 0 while their enable is high.
    always_comb begin
        t0 = (sys_cnt == SYS_MAX);
        t1 = t0 && (sam_phase == SAM_MAX);
        t2 = t1 && (sym_phase == SYM_MAX);

        sys_cnt_next = t0 ? '0 : sys_cnt + SYS_W'(1);

        sam_next = sam_phase;
        if (t1)
            sam_next = '0;
        else if (t0)
            sam_next = sam_phase + SAM_W'(1);

        sym_next = sym_phase;
        if (t2)
            sym_next = '0;
        else if (t1)
            sym_next = sym_phase + SYM_W'(1);
    end

    // sys_clk is high while the next count sits in the lower half of the
    // period, so its rising edge coincides with sys_clk_en. A divide-by-one
    // has no lower half and the clock stays low.
    generate
        if (SYS_DIV == 1) begin : g_no_div
            assign sys_clk_next = 1'b0;
        end else begin : g_div
            localparam logic [SYS_W-1:0] SYS_HALF = SYS_W'(SYS_DIV / 2);
            assign sys_clk_next = (sys_cnt_next < SYS_HALF);
        end
    endgenerate

    // Counter and output registers. sync restarts everything from zero and
    // wins over run; a hold freezes counters and sys_clk but drops every
    // enable so downstream blocks see no activity while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sys_cnt    <= '0;
            sam_phase  <= '0;
            sym_phase  <= '0;
            sys_clk    <= 1'b0;
            sys_clk_en <= 1'b0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
        end else if (sync) begin
            sys_cnt    <= '0;
            sam_phase  <= '0;
            sym_phase  <= '0;
            sys_clk    <= 1'b0;
            sys_clk_en <= 1'b0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
        end else if (run) begin
            sys_cnt    <= sys_cnt_next;
            sam_phase  <= sam_next;
            sym_phase  <= sym_next;
            sys_clk    <= sys_clk_next;
            sys_clk_en <= t0;
            sam_clk_en <= t1;
            sym_clk_en <= t2;
        end else begin
            sys_clk_en <= 1'b0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_en_multirate.sv
// ============================================================================
// tb_clk_en_multirate
// ----------------------------------------------------------------------------
// Bench for clk_en_multirate. Three instances run side by side from shared
// stimulus: the default 2/4/4 ratios, a 1/1/3 corner and a 3/5/2 set. Each
// edge's expected outputs for all three are derived arithmetically from the
// number of active edges since reset or re-align, pushed to a queue when the
// edge's stimulus is applied, and popped for comparison just after the edge.
// ============================================================================
module tb_clk_en_multirate;

    logic clk;
    logic reset;
    logic run;
    logic sync;

    logic       a_sys_clk, a_sys_en, a_sam_en, a_sym_en;
    logic [1:0] a_sam_phase;
    logic [1:0] a_sym_phase;

    logic       b_sys_clk, b_sys_en, b_sam_en, b_sym_en;
    logic [0:0] b_sam_phase;
    logic [1:0] b_sym_phase;

    logic       c_sys_clk, c_sys_en, c_sam_en, c_sym_en;
    logic [2:0] c_sam_phase;
    logic [0:0] c_sym_phase;

    int checks = 0;
    int errors = 0;

    // Active-edge counts and last expected vectors, one set per instance.
    int          k_a, k_b, k_c;
    logic [15:0] p_a, p_b, p_c;

    logic [47:0] sb_q[$];

    clk_en_multirate #(.SYS_DIV(2), .SAM_DIV(4), .SYM_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .run(run), .sync(sync),
        .sys_clk(a_sys_clk), .sys_clk_en(a_sys_en), .sam_clk_en(a_sam_en),
        .sym_clk_en(a_sym_en), .sam_phase(a_sam_phase), .sym_phase(a_sym_phase)
    );

    clk_en_multirate #(.SYS_DIV(1), .SAM_DIV(1), .SYM_DIV(3)) dut_b (
        .clk(clk), .reset(reset), .run(run), .sync(sync),
        .sys_clk(b_sys_clk), .sys_clk_en(b_sys_en), .sam_clk_en(b_sam_en),
        .sym_clk_en(b_sym_en), .sam_phase(b_sam_phase), .sym_phase(b_sym_phase)
    );

    clk_en_multirate #(.SYS_DIV(3), .SAM_DIV(5), .SYM_DIV(2)) dut_c (
        .clk(clk), .reset(reset), .run(run), .sync(sync),
        .sys_clk(c_sys_clk), .sys_clk_en(c_sys_en), .sam_clk_en(c_sam_en),
        .sym_clk_en(c_sym_en), .sam_phase(c_sam_phase), .sym_phase(c_sym_phase)
    );

    // Free-running master clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after active edge k, laid out as
    // {sys_clk, sys_en, sam_en, sym_en, sam_phase[5:0], sym_phase[5:0]}.
    function automatic logic [15:0] calc(input int sd, input int sa, input int sy, input int k);
        logic [15:0] v;
        v        = '0;
        v[15]    = ((k % sd) < (sd / 2));
        v[14]    = ((k % sd) == 0);
        v[13]    = ((k % (sd * sa)) == 0);
        v[12]    = ((k % (sd * sa * sy)) == 0);
        v[11:6]  = 6'((k / sd) % sa);
        v[5:0]   = 6'((k / (sd * sa)) % sy);
        return v;
    endfunction

    function automatic logic [47:0] obs_all();
        return {a_sys_clk, a_sys_en, a_sam_en, a_sym_en, 6'(a_sam_phase), 6'(a_sym_phase),
                b_sys_clk, b_sys_en, b_sam_en, b_sym_en, 6'(b_sam_phase), 6'(b_sym_phase),
                c_sys_clk, c_sys_en, c_sam_en, c_sym_en, 6'(c_sam_phase), 6'(c_sym_phase)};
    endfunction

    task automatic model_clear();
        k_a = 0; k_b = 0; k_c = 0;
        p_a = '0; p_b = '0; p_c = '0;
    endtask

    // Applies one edge's worth of stimulus, pushes what the three instances
    // must show after that edge, then waits until just after the edge.
    task automatic apply_stimulus(input logic r, input logic s);
        run  = r;
        sync = s;
        if (s) begin
            model_clear();
        end else if (r) begin
            k_a++; k_b++; k_c++;
            p_a = calc(2, 4, 4, k_a);
            p_b = calc(1, 1, 3, k_b);
            p_c = calc(3, 5, 2, k_c);
        end else begin
            p_a = p_a & 16'h8FFF;
            p_b = p_b & 16'h8FFF;
            p_c = p_c & 16'h8FFF;
        end
        sb_q.push_back({p_a, p_b, p_c});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        sync  = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        model_clear();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [47:0] got;
        reset = 1'b0;
        run   = 1'b0;
        sync  = 1'b0;
        model_clear();
        #1;
        got = obs_all();
        checks++;
        if (got !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got %h expected %h", got, 48'h0);
        end
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = obs_all();
        checks++;
        if (got !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_held_run: got %h expected %h", got, 48'h0);
        end
        #3;
        run   = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_default_rate();
        logic [47:0] got, exp;
        int a_sys_n = 0, a_sam_n = 0, a_sym_n = 0;
        int b_sam_n = 0, b_sym_n = 0;
        int c_clk_n = 0, c_sam_n = 0, c_sym_n = 0;
        int first_sys = 0, first_sam = 0, first_sym = 0, first_rise = 0;
        logic prev_clk = 1'b0;
        do_reset();
        for (int n = 1; n <= 320; n++) begin
            apply_stimulus(1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = obs_all();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL default_rate edge %0d: got %h expected %h", n, got, exp);
            end
            checks++;
            if ((c_sym_en && !c_sam_en) || (c_sam_en && !c_sys_en)) begin
                errors++;
                $display("[TB] FAIL align_c edge %0d: got sys/sam/sym %b%b%b", n, c_sys_en, c_sam_en, c_sym_en);
            end
            if (a_sys_en) begin a_sys_n++; if (first_sys == 0) first_sys = n; end
            if (a_sam_en) begin a_sam_n++; if (first_sam == 0) first_sam = n; end
            if (a_sym_en) begin a_sym_n++; if (first_sym == 0) first_sym = n; end
            if (a_sys_clk && !prev_clk && first_rise == 0) first_rise = n;
            prev_clk = a_sys_clk;
            if (b_sam_en) b_sam_n++;
            if (b_sym_en) b_sym_n++;
            if (c_sys_clk) c_clk_n++;
            if (c_sam_en) c_sam_n++;
            if (c_sym_en) c_sym_n++;
        end
        checks++;
        if (a_sys_n !== 160 || a_sam_n !== 40 || a_sym_n !== 10) begin
            errors++;
            $display("[TB] FAIL default_counts: got %0d/%0d/%0d expected 160/40/10", a_sys_n, a_sam_n, a_sym_n);
        end
        checks++;
        if (first_sys !== 2 || first_sam !== 8 || first_sym !== 32 || first_rise !== 2) begin
            errors++;
            $display("[TB] FAIL default_first: got sys %0d sam %0d sym %0d rise %0d expected 2/8/32/2",
                     first_sys, first_sam, first_sym, first_rise);
        end
        checks++;
        if (b_sam_n !== 320 || b_sym_n !== 106) begin
            errors++;
            $display("[TB] FAIL sweep_b_counts: got sam %0d sym %0d expected 320/106", b_sam_n, b_sym_n);
        end
        checks++;
        if (c_clk_n !== 106 || c_sam_n !== 21 || c_sym_n !== 10) begin
            errors++;
            $display("[TB] FAIL sweep_c_counts: got clk %0d sam %0d sym %0d expected 106/21/10",
                     c_clk_n, c_sam_n, c_sym_n);
        end
    endtask

    task automatic test_hold();
        logic [47:0] got, exp;
        int first_sam = 0, first_sym = 0;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            apply_stimulus((n >= 11 && n <= 15) ? 1'b0 : 1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = obs_all();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL hold edge %0d: got %h expected %h", n, got, exp);
            end
            if (n > 15 && a_sam_en && first_sam == 0) first_sam = n;
            if (n > 15 && a_sym_en && first_sym == 0) first_sym = n;
        end
        checks++;
        if (first_sam !== 21 || first_sym !== 37) begin
            errors++;
            $display("[TB] FAIL hold_resume: got sam %0d sym %0d expected 21/37", first_sam, first_sym);
        end
    endtask

    task automatic test_sync();
        logic [47:0] got, exp;
        int first_sym = 0;
        do_reset();
        for (int n = 1; n <= 60; n++) begin
            apply_stimulus(1'b1, (n == 13) ? 1'b1 : 1'b0);
            exp = sb_q.pop_front();
            got = obs_all();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL sync edge %0d: got %h expected %h", n, got, exp);
            end
            if (n == 13) begin
                checks++;
                if (got !== 48'h0) begin
                    errors++;
                    $display("[TB] FAIL sync_clear: got %h expected %h", got, 48'h0);
                end
            end
            if (n > 13 && a_sym_en && first_sym == 0) first_sym = n;
        end
        checks++;
        if (first_sym !== 45) begin
            errors++;
            $display("[TB] FAIL sync_realign: got first sym edge %0d expected 45", first_sym);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] got, exp;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            if (n >= 9 && n <= 12)
                apply_stimulus(n[0], 1'b1);
            else
                apply_stimulus(1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = obs_all();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL sync_long edge %0d: got %h expected %h", n, got, exp);
            end
            if (n >= 9 && n <= 12) begin
                checks++;
                if (got !== 48'h0) begin
                    errors++;
                    $display("[TB] FAIL sync_long_clear edge %0d: got %h expected %h", n, got, 48'h0);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [47:0] got, exp;
        int first_sym = 0;
        do_reset();
        for (int n = 1; n <= 19; n++) begin
            apply_stimulus(1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = obs_all();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL midrun_pre edge %0d: got %h expected %h", n, got, exp);
            end
        end
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        got = obs_all();
        checks++;
        if (got !== 48'h0) begin
            errors++;
            $display("[TB] FAIL midrun_async_clear: got %h expected %h", got, 48'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        got = obs_all();
        checks++;
        if (got !== 48'h0) begin
            errors++;
            $display("[TB] FAIL midrun_held: got %h expected %h", got, 48'h0);
        end
        #3;
        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            apply_stimulus(1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = obs_all();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL midrun_post edge %0d: got %h expected %h", n, got, exp);
            end
            if (a_sym_en && first_sym == 0) first_sym = n;
        end
        checks++;
        if (first_sym !== 32) begin
            errors++;
            $display("[TB] FAIL midrun_first_sym: got edge %0d expected 32", first_sym);
        end
    endtask

    task automatic test_random_run();
        logic [47:0] got, exp;
        logic r, s;
        do_reset();
        for (int n = 1; n <= 400; n++) begin
            r = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 40) == 0);
            apply_stimulus(r, s);
            exp = sb_q.pop_front();
            got = obs_all();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL random edge %0d: got %h expected %h", n, got, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b0;
        sync  = 1'b0;
        test_reset();
        test_default_rate();
        test_hold();
        test_sync();
        test_back_to_back();
        test_reset_midrun();
        test_random_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
